// File: rtl/kcomp_score.sv
// Downstream scorer for the keyword comparator: gathers hit statistics over a
// bounded window and issues a one-shot keyword decision.
module kcomp_score #(
  parameter int WIN_LEN    = 16,
  parameter int THRESH     = 4,
  parameter int RUN_THRESH = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       code_in,
  input  logic             code_valid,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] sep_cnt,
  output logic [CNT_W-1:0] max_run,
  output logic [CNT_W-1:0] err_cnt,
  output logic             match,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] RUN_THR_C = CNT_W'(RUN_THRESH);
  localparam logic [7:0]       WIN_LAST  = 8'(WIN_LEN);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] run, run_nxt;
  logic [CNT_W-1:0] hit_nxt, sep_nxt, max_nxt, err_nxt;
  logic [7:0]       sym, sym_nxt;
  logic             match_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // The decision is formed from the post-update counts of the closing symbol,
  // so match is registered together with the transition into DECIDE.
  always_comb begin
    state_nxt = state;
    hit_nxt   = hit_cnt;
    sep_nxt   = sep_cnt;
    max_nxt   = max_run;
    err_nxt   = err_cnt;
    run_nxt   = run;
    sym_nxt   = sym;
    match_nxt = match;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
          hit_nxt   = '0;
          sep_nxt   = '0;
          max_nxt   = '0;
          err_nxt   = '0;
          run_nxt   = '0;
          sym_nxt   = '0;
          match_nxt = 1'b0;
        end
      end
      ACCUM: begin
        if (code_valid) begin
          sym_nxt = sym + 8'd1;
          run_nxt = '0;
          case (code_in)
            8'd127: begin
              hit_nxt = sat_inc(hit_cnt);
              run_nxt = sat_inc(run);
              if (run_nxt > max_run) max_nxt = run_nxt;
            end
            8'd0, 8'd191: begin
            end
            8'd63: sep_nxt = sat_inc(sep_cnt);
            default: err_nxt = sat_inc(err_cnt);
          endcase
          if ((code_in == 8'd191) || (sym_nxt == WIN_LAST)) begin
            state_nxt = DECIDE;
            match_nxt = (hit_nxt >= THRESH_C) && (max_nxt >= RUN_THR_C);
          end
        end
      end
      DECIDE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      hit_cnt <= '0;
      sep_cnt <= '0;
      max_run <= '0;
      err_cnt <= '0;
      run     <= '0;
      sym     <= '0;
      match   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      hit_cnt <= hit_nxt;
      sep_cnt <= sep_nxt;
      max_run <= max_nxt;
      err_cnt <= err_nxt;
      run     <= run_nxt;
      sym     <= sym_nxt;
      match   <= match_nxt;
      busy    <= (state_nxt == ACCUM);
      done    <= (state_nxt == DECIDE);
    end
  end

endmodule

// File: tb/tb_kcomp_score.sv
// Self-checking bench for kcomp_score: history-based window model checked every
// cycle, directed windows with literal expectations, and a saturation instance.
module tb_kcomp_score;

  localparam int WIN = 16;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    code_in = 8'd0;
  logic          code_valid = 1'b0;
  logic          start = 1'b0;
  logic          start2 = 1'b0;
  logic          busy, match, done;
  logic [CW-1:0] hit_cnt, sep_cnt, max_run, err_cnt;
  logic          busy2, match2, done2;
  logic [3:0]    hit2, sep2, run2, err2;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  kcomp_score #(.WIN_LEN(WIN), .THRESH(4), .RUN_THRESH(2), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
    .start(start), .busy(busy), .hit_cnt(hit_cnt), .sep_cnt(sep_cnt),
    .max_run(max_run), .err_cnt(err_cnt), .match(match), .done(done)
  );

  kcomp_score #(.WIN_LEN(15), .THRESH(4), .RUN_THRESH(2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
    .start(start2), .busy(busy2), .hit_cnt(hit2), .sep_cnt(sep2),
    .max_run(run2), .err_cnt(err2), .match(match2), .done(done2)
  );

  always #5 clk = ~clk;

  // Model: remember every symbol of the open window and derive the statistics
  // from that history each time it grows.
  bit         m_accum = 1'b0, m_decide = 1'b0;
  int         n = 0;
  logic [7:0] win [0:255];
  int         e_hit = 0, e_sep = 0, e_run = 0, e_err = 0;
  bit         e_match = 1'b0, e_done = 1'b0, e_busy = 1'b0;

  function automatic int sat(input int x);
    return (x > (2**CW - 1)) ? (2**CW - 1) : x;
  endfunction

  function automatic void recompute();
    int h = 0, s = 0, e = 0, r = 0, best = 0;
    for (int i = 0; i < n; i++) begin
      case (win[i])
        8'd127: begin h++; r++; if (r > best) best = r; end
        8'd63:  begin s++; r = 0; end
        8'd0, 8'd191: r = 0;
        default: begin e++; r = 0; end
      endcase
    end
    e_hit = sat(h); e_sep = sat(s); e_err = sat(e); e_run = sat(best);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_accum = 0; m_decide = 0; n = 0;
      e_hit = 0; e_sep = 0; e_run = 0; e_err = 0;
      e_match = 0; e_done = 0; e_busy = 0;
    end else begin
      if (m_decide) begin
        m_decide = 0;
        e_done = 0;
      end else if (m_accum) begin
        if (code_valid) begin
          win[n] = code_in;
          n++;
          recompute();
          if (code_in == 8'd191 || n == WIN) begin
            e_match = (e_hit >= 4) && (e_run >= 2);
            m_accum = 0; m_decide = 1; e_done = 1;
          end
        end
      end else if (start) begin
        m_accum = 1; n = 0;
        e_hit = 0; e_sep = 0; e_run = 0; e_err = 0; e_match = 0;
      end
      e_busy = m_accum;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy",    32'(busy),    32'(e_busy));
      checkOutput("done",    32'(done),    32'(e_done));
      checkOutput("match",   32'(match),   32'(e_match));
      checkOutput("hit_cnt", 32'(hit_cnt), 32'(e_hit));
      checkOutput("sep_cnt", 32'(sep_cnt), 32'(e_sep));
      checkOutput("max_run", 32'(max_run), 32'(e_run));
      checkOutput("err_cnt", 32'(err_cnt), 32'(e_err));
    end
  end

  task automatic applyStimulus(input bit st, input logic [7:0] code, input bit valid);
    @(negedge clk);
    #1;
    start = st;
    code_in = code;
    code_valid = valid;
  endtask

  task automatic startWindow();
    applyStimulus(0, 8'd0, 0);
    applyStimulus(1, 8'd0, 0);
  endtask

  // Called right after the closing symbol is driven: done must appear one cycle later.
  task automatic expectWindow(input int h, input int s, input int r, input int e, input bit m);
    @(negedge clk);
    checkOutput("lit_done", 32'(done),    32'd1);
    checkOutput("lit_hit",  32'(hit_cnt), 32'(h));
    checkOutput("lit_sep",  32'(sep_cnt), 32'(s));
    checkOutput("lit_run",  32'(max_run), 32'(r));
    checkOutput("lit_err",  32'(err_cnt), 32'(e));
    checkOutput("lit_match", 32'(match),  32'(m));
  endtask

  initial begin
    logic [7:0] t2 [0:8];
    logic [7:0] t3 [0:4];
    logic [7:0] c;
    int         k;
    t2 = '{8'd127, 8'd63, 8'd127, 8'd63, 8'd127, 8'd63, 8'd127, 8'd0, 8'd191};
    t3 = '{8'd5, 8'd127, 8'd127, 8'd200, 8'd191};

    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_hit",  32'(hit_cnt), 32'd0);
    checkOutput("rst_match", 32'(match), 32'd0);

    // Full-length window closing on the 16th symbol
    startWindow();
    for (int i = 0; i < 16; i++)
      applyStimulus(0, (i < 3 || i == 4) ? 8'd127 : 8'd0, 1);
    expectWindow(4, 0, 3, 0, 1);

    // Separators break every run; early close on 191
    startWindow();
    for (int i = 0; i < 9; i++) applyStimulus(0, t2[i], 1);
    expectWindow(4, 3, 1, 0, 0);

    // Error codes with early close
    startWindow();
    for (int i = 0; i < 5; i++) applyStimulus(0, t3[i], 1);
    expectWindow(2, 0, 2, 2, 0);

    // Gaps do not count, a second start is ignored
    startWindow();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 8'd127, 1);
      applyStimulus(i == 4, 8'd63, 0);
    end
    for (int i = 0; i < 6; i++) applyStimulus(0, 8'd0, 1);
    expectWindow(10, 0, 10, 0, 1);

    // Reset mid-window abandons it; codes ignored until the next start
    startWindow();
    for (int i = 0; i < 5; i++) applyStimulus(0, 8'd127, 1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_hit",  32'(hit_cnt), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy),    32'd0);
    checkOutput("mid_rst_done", 32'(done),    32'd0);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'd127, 1);
    @(negedge clk);
    checkOutput("post_rst_hit",  32'(hit_cnt), 32'd0);
    checkOutput("post_rst_busy", 32'(busy),    32'd0);

    // Narrow-counter instance: 15 hits hit the 4-bit ceiling exactly
    applyStimulus(0, 8'd0, 0);
    @(negedge clk);
    #1 start2 = 1'b1;
    @(negedge clk);
    #1 start2 = 1'b0;
    for (int i = 0; i < 15; i++) applyStimulus(0, 8'd127, 1);
    @(negedge clk);
    checkOutput("sat_done",  32'(done2),  32'd1);
    checkOutput("sat_hit",   32'(hit2),   32'd15);
    checkOutput("sat_run",   32'(run2),   32'd15);
    checkOutput("sat_sep",   32'(sep2),   32'd0);
    checkOutput("sat_err",   32'(err2),   32'd0);
    checkOutput("sat_match", 32'(match2), 32'd1);
    checkOutput("sat_busy",  32'(busy2),  32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      k = int'($urandom_range(0, 15));
      if (k < 8)        c = 8'd127;
      else if (k < 10)  c = 8'd0;
      else if (k == 10) c = 8'd63;
      else if (k == 11) c = 8'd191;
      else              c = 8'($urandom_range(0, 255));
      applyStimulus($urandom_range(0, 11) == 0, c, $urandom_range(0, 4) != 0);
      reset = ($urandom_range(0, 399) != 0);
    end
    applyStimulus(0, 8'd0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
